// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the multi-channel pulse generator.
// The state enum is used by every channel instance; CNT_W_DEFAULT sizes the count fields.
package pulse_gen_pkg;

  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } pulse_state_e;

endpackage

// File: rtl/pulse_gen_chan.sv
// One pulse channel: programmable delay, width, gap and repeat count, with a wait_on release
// qualifier. Optional wait_on timeout is compiled in with the PULSE_GEN_TIMEOUT_EN macro.
module pulse_gen_chan
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] delay_cnt,
  input  logic [CNT_W-1:0] width_cnt,
  input  logic [CNT_W-1:0] gap_cnt,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             wait_on,
  input  logic [CNT_W-1:0] timeout_cnt,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  pulse_state_e     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_delay_m1;
  logic [CNT_W-1:0] r_width_m1;
  logic [CNT_W-1:0] r_gap_m1;
  logic [CNT_W-1:0] r_rep;
  logic             r_done;
  logic             r_timeout;

  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_delay_met;
  logic             w_width_met;
  logic             w_gap_met;
  logic             w_release;
  logic             w_to_hit;

  // In-state counter holds at all-ones so a long wait_on stall never re-arms the width check.
  assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + ONE;
  assign w_delay_met = (r_cnt >= r_delay_m1);
  assign w_width_met = (r_cnt >= r_width_m1);
  assign w_gap_met   = (r_cnt >= r_gap_m1);
  assign w_release   = w_width_met && wait_on;

`ifdef PULSE_GEN_TIMEOUT_EN
  assign w_to_hit = (timeout_cnt != '0) && w_width_met && !wait_on && (r_cnt >= timeout_cnt);
`else
  logic w_unused_timeout_cnt;
  assign w_unused_timeout_cnt = ^timeout_cnt;
  assign w_to_hit             = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_delay_m1 <= '0;
      r_width_m1 <= '0;
      r_gap_m1   <= '0;
      r_rep      <= '0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_cnt <= '0;
            if (start) begin
              // Stored as "last count" values; zero width and zero gap collapse to one cycle.
              r_delay_m1 <= delay_cnt - ONE;
              r_width_m1 <= (width_cnt == '0) ? '0 : width_cnt - ONE;
              r_gap_m1   <= (gap_cnt == '0) ? '0 : gap_cnt - ONE;
              r_rep      <= repeat_cnt;
              r_state    <= (delay_cnt != '0) ? DELAY : PULSE;
            end
          end
          DELAY: begin
            if (w_delay_met) begin
              r_state <= PULSE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          PULSE: begin
            if (w_release) begin
              r_cnt <= '0;
              if (r_rep != '0) begin
                r_rep   <= r_rep - ONE;
                r_state <= GAP;
              end else begin
                r_state <= IDLE;
                r_done  <= 1'b1;
              end
            end else if (w_to_hit) begin
              r_cnt     <= '0;
              r_state   <= IDLE;
              r_timeout <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          GAP: begin
            if (w_gap_met) begin
              r_state <= PULSE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign pulse   = (r_state == PULSE);
  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign timeout = r_timeout;

endmodule

// File: rtl/multi_pulse_gen.sv
// NUM_CH independent pulse channels sharing one clock, reset and timeout limit.
// Timeout support is selected by the PULSE_GEN_TIMEOUT_EN macro inside pulse_gen_chan.
module multi_pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       abort,
  input  logic [NUM_CH*CNT_W-1:0] delay_cnt,
  input  logic [NUM_CH*CNT_W-1:0] width_cnt,
  input  logic [NUM_CH*CNT_W-1:0] gap_cnt,
  input  logic [NUM_CH*CNT_W-1:0] repeat_cnt,
  input  logic [NUM_CH-1:0]       wait_on,
  input  logic [CNT_W-1:0]        timeout_cnt,
  output logic [NUM_CH-1:0]       pulse,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       timeout
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    pulse_gen_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .start       (start[gi]),
      .abort       (abort[gi]),
      .delay_cnt   (delay_cnt[gi*CNT_W +: CNT_W]),
      .width_cnt   (width_cnt[gi*CNT_W +: CNT_W]),
      .gap_cnt     (gap_cnt[gi*CNT_W +: CNT_W]),
      .repeat_cnt  (repeat_cnt[gi*CNT_W +: CNT_W]),
      .wait_on     (wait_on[gi]),
      .timeout_cnt (timeout_cnt),
      .pulse       (pulse[gi]),
      .busy        (busy[gi]),
      .done        (done[gi]),
      .timeout     (timeout[gi])
    );
  end

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Self-checking bench for multi_pulse_gen: directed scenarios plus randomized multi-channel runs
// compared against an arithmetic waveform model. Honors PULSE_GEN_TIMEOUT_EN like the design.
module tb_multi_pulse_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic                    clk;
  logic                    reset;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       abort;
  logic [NUM_CH*CNT_W-1:0] delay_cnt;
  logic [NUM_CH*CNT_W-1:0] width_cnt;
  logic [NUM_CH*CNT_W-1:0] gap_cnt;
  logic [NUM_CH*CNT_W-1:0] repeat_cnt;
  logic [NUM_CH-1:0]       wait_on;
  logic [CNT_W-1:0]        timeout_cnt;
  logic [NUM_CH-1:0]       pulse;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH-1:0]       timeout;

  int n_checks = 0;
  int n_fails  = 0;

  multi_pulse_gen #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .delay_cnt   (delay_cnt),
    .width_cnt   (width_cnt),
    .gap_cnt     (gap_cnt),
    .repeat_cnt  (repeat_cnt),
    .wait_on     (wait_on),
    .timeout_cnt (timeout_cnt),
    .pulse       (pulse),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle t is the cycle after the t-th edge following the cycle in which start was sampled.
  function automatic int done_time(int d, int w, int g, int r);
    int we = (w == 0) ? 1 : w;
    int ge = (g == 0) ? 1 : g;
    return d + 1 + r * (we + ge) + we;
  endfunction

  // Expected {pulse, busy, done, timeout} at cycle t, wait_on held high.
  function automatic logic [3:0] model(int t, int d, int w, int g, int r);
    int we = (w == 0) ? 1 : w;
    int ge = (g == 0) ? 1 : g;
    int p  = we + ge;
    int dt = done_time(d, w, g, r);
    int t0 = t - d - 1;
    if (t < 1 || t > dt) return 4'b0000;
    if (t == dt) return 4'b0010;
    if (t0 < 0) return 4'b0100;
    return {((t0 % p) < we), 1'b1, 2'b00};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(int ch, int d, int w, int g, int r);
    delay_cnt[ch*CNT_W +: CNT_W]  = CNT_W'(d);
    width_cnt[ch*CNT_W +: CNT_W]  = CNT_W'(w);
    gap_cnt[ch*CNT_W +: CNT_W]    = CNT_W'(g);
    repeat_cnt[ch*CNT_W +: CNT_W] = CNT_W'(r);
  endtask

  task automatic scramble_cfg(int ch);
    set_cfg(ch, int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
            int'($urandom_range(255, 0)), int'($urandom_range(255, 0)));
  endtask

  task automatic chk(string tag, int ch, int t, logic [3:0] exp_v);
    logic [3:0] got;
    got = {pulse[ch], busy[ch], done[ch], timeout[ch]};
    n_checks++;
    assert (got === exp_v)
    else begin
      n_fails++;
      $error("FAIL %s ch%0d t=%0d {pulse,busy,done,timeout} got=%b exp=%b", tag, ch, t, got, exp_v);
    end
  endtask

  // Single channel run; config is scrambled and start is pulsed randomly while the channel is busy.
  task automatic run_single(string tag, int ch, int d, int w, int g, int r);
    int dt = done_time(d, w, g, r);
    set_cfg(ch, d, w, g, r);
    wait_on[ch] = 1'b1;
    start[ch]   = 1'b1;
    for (int t = 1; t <= dt + 2; t++) begin
      step();
      chk(tag, ch, t, model(t, d, w, g, r));
      start[ch] = (t < dt) ? 1'($urandom_range(1, 0)) : 1'b0;
      scramble_cfg(ch);
    end
    start[ch] = 1'b0;
  endtask

  // wait_on low for cycles 1..low_cyc, high afterwards; single pulse, no repeats.
  task automatic run_wait(string tag, int ch, int w, int low_cyc, int to_lim);
    int rel = (low_cyc + 1 > w) ? low_cyc + 1 : w;
    set_cfg(ch, 0, w, 0, 0);
    timeout_cnt = CNT_W'(to_lim);
    wait_on[ch] = 1'b0;
    start[ch]   = 1'b1;
    for (int t = 1; t <= rel + 2; t++) begin
      step();
      start[ch]   = 1'b0;
      wait_on[ch] = (t >= low_cyc + 1);
      chk(tag, ch, t, (t <= rel) ? 4'b1100 : (t == rel + 1) ? 4'b0010 : 4'b0000);
    end
    wait_on[ch] = 1'b1;
  endtask

  initial begin
    int d [NUM_CH];
    int w [NUM_CH];
    int g [NUM_CH];
    int r [NUM_CH];
    int st[NUM_CH];
    int dt[NUM_CH];
    int max_t;
    int t;

    reset       = 1'b1;
    start       = '0;
    abort       = '0;
    delay_cnt   = '0;
    width_cnt   = '0;
    gap_cnt     = '0;
    repeat_cnt  = '0;
    wait_on     = '1;
    timeout_cnt = '0;
    step();
    step();
    for (int ch = 0; ch < NUM_CH; ch++) chk("reset", ch, 0, 4'b0000);
    reset = 1'b0;
    step();

    // Basic single pulse, delayed repeats, and width/gap zero boundaries
    run_single("basic_w3", 0, 0, 3, 0, 0);
    run_single("delay_rep", 1, 2, 2, 1, 2);
    run_single("zero_wg", 2, 1, 0, 0, 3);
    run_single("rep_all_ones", 3, 0, 1, 1, 255);

    // wait_on stretch, and a stall long enough that a wrapping counter would re-arm width
    run_wait("wait_on", 2, 1, 10, 0);
    run_wait("cnt_sat", 0, 3, 256, 0);

    // Abort in GAP on ch3 while ch0 sees start and abort together
    set_cfg(3, 1, 2, 4, 1);
    set_cfg(0, 0, 3, 0, 0);
    start[3] = 1'b1;
    start[0] = 1'b1;
    abort[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      start    = '0;
      abort[0] = 1'b0;
      chk("abort_gap", 3, k, (k <= 5) ? model(k, 1, 2, 4, 1) : 4'b0000);
      chk("start_abort", 0, k, 4'b0000);
      abort[3] = (k == 5);
    end
    abort = '0;

    // Reset mid-pulse overrides start and abort, then a fresh start runs normally
    for (int ch = 0; ch < NUM_CH; ch++) set_cfg(ch, 0, 5, 0, 0);
    start = '1;
    step();
    start = '0;
    step();
    for (int ch = 0; ch < NUM_CH; ch++) chk("pre_reset", ch, 2, 4'b1100);
    reset = 1'b1;
    start = '1;
    abort = '1;
    step();
    for (int ch = 0; ch < NUM_CH; ch++) chk("reset_mid", ch, 0, 4'b0000);
    reset = 1'b0;
    abort = '0;
    for (int k = 1; k <= 7; k++) begin
      step();
      start = '0;
      for (int ch = 0; ch < NUM_CH; ch++) chk("post_reset", ch, k, model(k, 0, 5, 0, 0));
    end

`ifdef PULSE_GEN_TIMEOUT_EN
    set_cfg(1, 0, 2, 0, 0);
    timeout_cnt = CNT_W'(5);
    wait_on[1]  = 1'b0;
    start[1]    = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      start[1] = 1'b0;
      chk("timeout", 1, k, (k <= 6) ? 4'b1100 : (k == 7) ? 4'b0001 : 4'b0000);
    end
    wait_on[1]  = 1'b1;
    timeout_cnt = '0;
`else
    run_wait("no_timeout", 1, 2, 11, 5);
    timeout_cnt = '0;
`endif

    // Randomized concurrent channels with staggered starts
    for (int iter = 0; iter < 6; iter++) begin
      max_t = 0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        d[ch]  = int'($urandom_range(4, 0));
        w[ch]  = int'($urandom_range(4, 0));
        g[ch]  = int'($urandom_range(3, 0));
        r[ch]  = int'($urandom_range(3, 0));
        st[ch] = int'($urandom_range(3, 0));
        dt[ch] = done_time(d[ch], w[ch], g[ch], r[ch]);
        if (st[ch] + dt[ch] + 2 > max_t) max_t = st[ch] + dt[ch] + 2;
      end
      timeout_cnt = CNT_W'($urandom_range(255, 0));
      for (int tt = 0; tt <= max_t; tt++) begin
        if (tt > 0) step();
        for (int ch = 0; ch < NUM_CH; ch++) begin
          t = tt - st[ch];
          if (tt > 0) chk("rnd", ch, t, model(t, d[ch], w[ch], g[ch], r[ch]));
          if (t == 0) begin
            set_cfg(ch, d[ch], w[ch], g[ch], r[ch]);
            start[ch] = 1'b1;
          end else begin
            start[ch] = (t >= 1 && t < dt[ch]) ? 1'($urandom_range(1, 0)) : 1'b0;
            scramble_cfg(ch);
          end
        end
      end
      start = '0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
